// File: rtl/mctrl_pkg.sv
// mctrl_pkg: shared opcodes, ALU codes, FSM states and control-register layout
package mctrl_pkg;
  localparam int TIMEOUT_DEF = 15;
  localparam logic [5:0] OP_RTYPE = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001110;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_SUB   = 6'b100010;
  localparam logic [5:0] FN_AND   = 6'b100100;
  localparam logic [5:0] FN_OR    = 6'b100101;
  localparam logic [5:0] FN_X     = 6'b110010;
  localparam logic [2:0] ALU_ADD  = 3'd0;
  localparam logic [2:0] ALU_SUB  = 3'd1;
  localparam logic [2:0] ALU_AND  = 3'd2;
  localparam logic [2:0] ALU_OR   = 3'd3;
  localparam logic [2:0] ALU_LUI  = 3'd4;
  localparam logic [2:0] ALU_X    = 3'd5;
  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, FAULT} state_t;
  typedef struct packed {
    logic       legal;
    logic       is_lw;
    logic       is_sw;
    logic       reg_dst_rd;
    logic       alu_src_imm;
    logic       imm_upper;
    logic [2:0] alu_op;
  } ctrl_t;
endpackage

// File: rtl/mctrl_seq_if.sv
// mctrl_seq_if: fetch/data handshakes and datapath strobes; retired counter port only with MCTRL_SEQ_PERF_EN
interface mctrl_seq_if;
  logic [31:0] instr;
  logic        imem_req, imem_ack, dmem_req, dmem_we, dmem_ack;
  logic        ir_we, pc_we, reg_we, reg_dst_rd, alu_src_imm, imm_upper, mem_to_reg;
  logic [2:0]  alu_op;
  logic        busy, fault;
`ifdef MCTRL_SEQ_PERF_EN
  logic [31:0] retired;
  modport master(input instr, imem_ack, dmem_ack,
                 output imem_req, dmem_req, dmem_we, ir_we, pc_we, reg_we, reg_dst_rd,
                        alu_src_imm, imm_upper, mem_to_reg, alu_op, busy, fault, retired);
  modport slave(output instr, imem_ack, dmem_ack,
                input imem_req, dmem_req, dmem_we, ir_we, pc_we, reg_we, reg_dst_rd,
                      alu_src_imm, imm_upper, mem_to_reg, alu_op, busy, fault, retired);
`else
  modport master(input instr, imem_ack, dmem_ack,
                 output imem_req, dmem_req, dmem_we, ir_we, pc_we, reg_we, reg_dst_rd,
                        alu_src_imm, imm_upper, mem_to_reg, alu_op, busy, fault);
  modport slave(output instr, imem_ack, dmem_ack,
                input imem_req, dmem_req, dmem_we, ir_we, pc_we, reg_we, reg_dst_rd,
                      alu_src_imm, imm_upper, mem_to_reg, alu_op, busy, fault);
`endif
endinterface

// File: rtl/mctrl_decode.sv
// mctrl_decode: combinational instruction decoder producing control fields and legality
module mctrl_decode
  import mctrl_pkg::*;
(
  input  logic [31:0] instr,
  output ctrl_t       ctrl
);
  logic [5:0] op, fn;
  logic unused_bits;
  assign op = instr[31:26];
  assign fn = instr[5:0];
  assign unused_bits = ^instr[25:6];
  // map opcode/funct to control fields; anything unrecognised stays all-zero (illegal)
  always_comb begin
    ctrl = '0;
    case (op)
      OP_RTYPE: begin
        ctrl.legal = 1'b1;
        ctrl.reg_dst_rd = 1'b1;
        case (fn)
          FN_ADD: ctrl.alu_op = ALU_ADD;
          FN_SUB: ctrl.alu_op = ALU_SUB;
          FN_AND: ctrl.alu_op = ALU_AND;
          FN_OR:  ctrl.alu_op = ALU_OR;
          FN_X:   ctrl.alu_op = ALU_X;
          default: ctrl = '0;
        endcase
      end
      OP_ORI: begin
        ctrl.legal = 1'b1;
        ctrl.alu_src_imm = 1'b1;
        ctrl.alu_op = ALU_OR;
      end
      OP_LUI: begin
        ctrl.legal = 1'b1;
        ctrl.imm_upper = 1'b1;
        ctrl.alu_op = ALU_LUI;
      end
      OP_LW: begin
        ctrl.legal = 1'b1;
        ctrl.is_lw = 1'b1;
        ctrl.alu_src_imm = 1'b1;
      end
      OP_SW: begin
        ctrl.legal = 1'b1;
        ctrl.is_sw = 1'b1;
        ctrl.alu_src_imm = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end
endmodule

// File: rtl/mctrl_seq.sv
// mctrl_seq: multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer with handshake timeout; MCTRL_SEQ_PERF_EN adds retired counter
module mctrl_seq
  import mctrl_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int TO_W    = 8
)(
  input  logic        clk,
  input  logic        rst,
  mctrl_seq_if.master m
);
  state_t          state, state_n;
  ctrl_t           ctrl, dec;
  logic [TO_W-1:0] to_cnt;
  logic            act, expired, fetch_ack, sel;
  mctrl_decode u_dec (.instr(m.instr), .ctrl(dec));
  assign act = !rst;
  assign expired = to_cnt == TO_W'(TIMEOUT - 1);
  assign fetch_ack = act && state == FETCH && m.imem_ack;
  assign sel = act && (state == EXEC || state == MEM || state == WB);
  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= FETCH;
    else state <= state_n;
  // control register captures the decode of the fetched word while it is valid
  always_ff @(posedge clk or posedge rst)
    if (rst) ctrl <= '0;
    else if (fetch_ack) ctrl <= dec;
  // request-wait counter: restarts on every state change, counts while a request waits
  always_ff @(posedge clk or posedge rst)
    if (rst) to_cnt <= '0;
    else to_cnt <= state_n != state ? '0 : (state == FETCH || state == MEM) ? to_cnt + 1'b1 : to_cnt;
  // next state and outputs; ack takes priority over timeout, reset silences everything but busy
  always_comb begin
    state_n = state;
    case (state)
      FETCH:   state_n = m.imem_ack ? DECODE : expired ? FAULT : FETCH;
      DECODE:  state_n = ctrl.legal ? EXEC : FAULT;
      EXEC:    state_n = (ctrl.is_lw || ctrl.is_sw) ? MEM : WB;
      MEM:     state_n = m.dmem_ack ? (ctrl.is_sw ? FETCH : WB) : expired ? FAULT : MEM;
      WB:      state_n = FETCH;
      default: state_n = FAULT;
    endcase
    m.imem_req    = act && state == FETCH;
    m.ir_we       = fetch_ack;
    m.pc_we       = fetch_ack;
    m.dmem_req    = act && state == MEM;
    m.dmem_we     = act && state == MEM && ctrl.is_sw;
    m.reg_we      = act && state == WB;
    m.reg_dst_rd  = sel && ctrl.reg_dst_rd;
    m.alu_src_imm = sel && ctrl.alu_src_imm;
    m.imm_upper   = sel && ctrl.imm_upper;
    m.mem_to_reg  = sel && ctrl.is_lw;
    m.alu_op      = sel ? ctrl.alu_op : ALU_ADD;
    m.busy        = state != FAULT;
    m.fault       = act && state == FAULT;
  end
`ifdef MCTRL_SEQ_PERF_EN
  logic [31:0] retired_q;
  assign m.retired = retired_q;
  // an instruction retires when WB completes or a store is acknowledged
  always_ff @(posedge clk or posedge rst)
    if (rst) retired_q <= '0;
    else if (state == WB || (state == MEM && ctrl.is_sw && m.dmem_ack)) retired_q <= retired_q + 1'b1;
`endif
endmodule

// File: tb/tb_mctrl_seq.sv
// tb_mctrl_seq: directed self-checking bench for mctrl_seq (retired checks only with MCTRL_SEQ_PERF_EN)
module tb_mctrl_seq;
  localparam logic [14:0] IREQ = 15'h4000, DREQ = 15'h2000, DWE = 15'h1000, IRWE = 15'h0800,
                          PCWE = 15'h0400, REGWE = 15'h0200, RD = 15'h0100, IMM = 15'h0080,
                          UP = 15'h0040, M2R = 15'h0020, BUSY = 15'h0002, FLT = 15'h0001;
  localparam logic [14:0] OP1 = 15'h0004, OP2 = 15'h0008, OP3 = 15'h000C, OP4 = 15'h0010, OP5 = 15'h0014;
  localparam logic [14:0] FA = IREQ | IRWE | PCWE | BUSY;
  logic clk = 1'b0, rst;
  int checks = 0, errors = 0;
  logic [14:0] ov;
  mctrl_seq_if bus();
  mctrl_seq dut (.clk(clk), .rst(rst), .m(bus));
  always #5 clk = ~clk;
  assign ov = {bus.imem_req, bus.dmem_req, bus.dmem_we, bus.ir_we, bus.pc_we, bus.reg_we,
               bus.reg_dst_rd, bus.alu_src_imm, bus.imm_upper, bus.mem_to_reg, bus.alu_op,
               bus.busy, bus.fault};
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask
  task automatic cyc(input logic ia, input logic da, input logic [14:0] exp, input string tag);
    bus.imem_ack = ia;
    bus.dmem_ack = da;
    @(negedge clk);
    check(tag, 32'(ov), 32'(exp));
    @(posedge clk);
    #1;
  endtask
  task automatic do_rst(input string tag);
    rst = 1'b1;
    bus.imem_ack = 1'b0;
    bus.dmem_ack = 1'b0;
    @(negedge clk);
    check(tag, 32'(ov), 32'(BUSY));
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask
  task automatic run_alu(input logic [31:0] ins, input logic [14:0] s, input string tag);
    bus.instr = ins;
    cyc(1'b1, 1'b0, FA, {tag, "_f"});
    cyc(1'b1, 1'b1, BUSY, {tag, "_d"});
    cyc(1'b1, 1'b1, s | BUSY, {tag, "_e"});
    cyc(1'b0, 1'b0, REGWE | s | BUSY, {tag, "_wb"});
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1);
  end
  initial begin
    rst = 1'b1;
    bus.instr = 32'h34013000;
    bus.imem_ack = 1'b0;
    bus.dmem_ack = 1'b0;
    @(posedge clk);
    #1;
    do_rst("reset");
    run_alu(32'h34013000, IMM | OP3, "ori");
    run_alu(32'h38010005, UP | OP4, "lui");
    run_alu(32'h30011024, RD | OP2, "and");
    run_alu(32'h30011032, RD | OP5, "op5");
    bus.instr = 32'h30011022;
    repeat (3) cyc(1'b0, 1'b0, IREQ | BUSY, "sub_wait");
    cyc(1'b1, 1'b0, FA, "sub_f");
    cyc(1'b0, 1'b0, BUSY, "sub_d");
    cyc(1'b0, 1'b0, RD | OP1 | BUSY, "sub_e");
    cyc(1'b0, 1'b0, REGWE | RD | OP1 | BUSY, "sub_wb");
    bus.instr = 32'h8C220004;
    cyc(1'b1, 1'b0, FA, "lw_f");
    cyc(1'b0, 1'b0, BUSY, "lw_d");
    cyc(1'b0, 1'b0, IMM | M2R | BUSY, "lw_e");
    cyc(1'b0, 1'b0, DREQ | IMM | M2R | BUSY, "lw_m1");
    cyc(1'b0, 1'b0, DREQ | IMM | M2R | BUSY, "lw_m2");
    cyc(1'b0, 1'b1, DREQ | IMM | M2R | BUSY, "lw_m3");
    cyc(1'b0, 1'b0, REGWE | IMM | M2R | BUSY, "lw_wb");
    bus.instr = 32'hAC220004;
    cyc(1'b1, 1'b0, FA, "sw_f");
    cyc(1'b0, 1'b0, BUSY, "sw_d");
    cyc(1'b0, 1'b0, IMM | BUSY, "sw_e");
    cyc(1'b0, 1'b0, DREQ | DWE | IMM | BUSY, "sw_m1");
    cyc(1'b0, 1'b0, DREQ | DWE | IMM | BUSY, "sw_m2");
    cyc(1'b0, 1'b1, DREQ | DWE | IMM | BUSY, "sw_m3");
    cyc(1'b0, 1'b0, IREQ | BUSY, "sw_next");
    cyc(1'b1, 1'b0, FA, "sw2_f");
    cyc(1'b0, 1'b0, BUSY, "sw2_d");
    cyc(1'b0, 1'b0, IMM | BUSY, "sw2_e");
    cyc(1'b0, 1'b0, DREQ | DWE | IMM | BUSY, "sw2_m");
    rst = 1'b1;
    #1;
    check("rst_mid_mem", 32'(ov), 32'(BUSY));
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc(1'b0, 1'b0, IREQ | BUSY, "resume");
    bus.instr = 32'hFC000000;
    cyc(1'b1, 1'b0, FA, "ill_f");
    cyc(1'b0, 1'b0, BUSY, "ill_d");
    repeat (3) cyc(1'b1, 1'b1, FLT, "ill_fault");
    do_rst("reset_ill");
    bus.instr = 32'h30011021;
    cyc(1'b1, 1'b0, FA, "badfn_f");
    cyc(1'b0, 1'b0, BUSY, "badfn_d");
    cyc(1'b0, 1'b0, FLT, "badfn_fault");
    do_rst("reset_badfn");
    repeat (15) cyc(1'b0, 1'b0, IREQ | BUSY, "to_wait");
    cyc(1'b0, 1'b0, FLT, "to_fault");
    cyc(1'b1, 1'b0, FLT, "to_hold");
    do_rst("reset_to");
    bus.instr = 32'h34013000;
    repeat (14) cyc(1'b0, 1'b0, IREQ | BUSY, "to15_wait");
    cyc(1'b1, 1'b0, FA, "to15_ack");
    cyc(1'b0, 1'b0, BUSY, "to15_d");
    cyc(1'b0, 1'b0, IMM | OP3 | BUSY, "to15_e");
    cyc(1'b0, 1'b0, REGWE | IMM | OP3 | BUSY, "to15_wb");
    bus.instr = 32'h8C220004;
    cyc(1'b1, 1'b0, FA, "dto_f");
    cyc(1'b0, 1'b0, BUSY, "dto_d");
    cyc(1'b0, 1'b0, IMM | M2R | BUSY, "dto_e");
    repeat (15) cyc(1'b0, 1'b0, DREQ | IMM | M2R | BUSY, "dto_wait");
    cyc(1'b0, 1'b0, FLT, "dto_fault");
`ifdef MCTRL_SEQ_PERF_EN
    do_rst("reset_perf");
    check("retired_rst", bus.retired, 32'd0);
    run_alu(32'h30011020, RD, "p_add");
    run_alu(32'h34013000, IMM | OP3, "p_ori");
    run_alu(32'h30011025, RD | OP3, "p_or");
    @(negedge clk);
    check("retired_3", bus.retired, 32'd3);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
